// File: rtl/add_iq_pkg.sv
// Shared types and helpers for the ADD issue queue: entry layout, width constants,
// operand wakeup against the two writeback broadcast buses.
package add_iq_pkg;

    localparam int PREG_W = 5;
    localparam int DATA_W = 16;
    localparam int ROB_W  = 4;

    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] Pw;
        logic [PREG_W-1:0] Pa;
        logic [PREG_W-1:0] Pb;
        logic              rdyA;
        logic              rdyB;
        logic [DATA_W-1:0] valA;
        logic [DATA_W-1:0] valB;
        logic [ROB_W-1:0]  tag_ROB;
    } iq_entry_t;

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Capture a broadcast into any still-waiting source; wb0 wins a tag tie.
    function automatic iq_entry_t wakeup(
        input iq_entry_t         e,
        input logic              v0,
        input logic [PREG_W-1:0] t0,
        input logic [DATA_W-1:0] d0,
        input logic              v1,
        input logic [PREG_W-1:0] t1,
        input logic [DATA_W-1:0] d1
    );
        iq_entry_t r;
        r = e;
        if (e.valid && !e.rdyA) begin
            if (v0 && t0 == e.Pa) begin
                r.rdyA = 1'b1;
                r.valA = d0;
            end else if (v1 && t1 == e.Pa) begin
                r.rdyA = 1'b1;
                r.valA = d1;
            end
        end
        if (e.valid && !e.rdyB) begin
            if (v0 && t0 == e.Pb) begin
                r.rdyB = 1'b1;
                r.valB = d0;
            end else if (v1 && t1 == e.Pb) begin
                r.rdyB = 1'b1;
                r.valB = d1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_issue_queue_select.sv
// Oldest-first select: one-hot grant and binary index of the lowest-index request.
module iq_oldest_select
    import add_iq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = idx_w(DEPTH)
) (
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IDX_W'(i);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_issue_queue.sv
// Collapsing, data-capturing reservation station feeding the 16-bit ADD unit.
// Build option ADD_IQ_FAST_WAKEUP_EN lets select see same-cycle broadcasts.
module add_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int PREG_W = 5,
    parameter int DATA_W = 16,
    parameter int ROB_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze_back,
    input  logic              valid_dispatch,
    input  logic [PREG_W-1:0] Pw_dispatch,
    input  logic [PREG_W-1:0] Pa_dispatch,
    input  logic [PREG_W-1:0] Pb_dispatch,
    input  logic              rdyA_dispatch,
    input  logic              rdyB_dispatch,
    input  logic [DATA_W-1:0] valA_dispatch,
    input  logic [DATA_W-1:0] valB_dispatch,
    input  logic [ROB_W-1:0]  tag_ROB_dispatch,
    output logic              ready_dispatch,
    input  logic              valid_wb0,
    input  logic              valid_wb1,
    input  logic [PREG_W-1:0] Pw_wb0,
    input  logic [PREG_W-1:0] Pw_wb1,
    input  logic [DATA_W-1:0] Result_wb0,
    input  logic [DATA_W-1:0] Result_wb1,
    output logic              valid_add,
    output logic [PREG_W-1:0] Pw_add,
    output logic [DATA_W-1:0] busA_add,
    output logic [DATA_W-1:0] busB_add,
    output logic [ROB_W-1:0]  tag_ROB_add
);
    import add_iq_pkg::iq_entry_t;
    import add_iq_pkg::wakeup;
    import add_iq_pkg::idx_w;

    localparam int IDX_W = idx_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry layout is fixed by the package; overriding widths is unsupported.
    if (PREG_W != add_iq_pkg::PREG_W || DATA_W != add_iq_pkg::DATA_W ||
        ROB_W != add_iq_pkg::ROB_W || DEPTH < 2 || DEPTH > 8) begin : g_param_chk
        $error("add_issue_queue: unsupported parameter set");
    end

    iq_entry_t [DEPTH-1:0] q_q, q_d, wk, up;
    iq_entry_t             nd;
    logic [CNT_W-1:0]      count_q, count_d, slot;
    logic [DEPTH-1:0]      req, gnt;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any, issue, accept;
    logic [PREG_W-1:0]     sel_pw;
    logic [DATA_W-1:0]     sel_a, sel_b;
    logic [ROB_W-1:0]      sel_tag;

    logic              valid_add_q, valid_add_d;
    logic [PREG_W-1:0] pw_add_q, pw_add_d;
    logic [DATA_W-1:0] busa_q, busa_d, busb_q, busb_d;
    logic [ROB_W-1:0]  tag_q, tag_d;

    assign ready_dispatch = (count_q < CNT_W'(DEPTH));
    assign issue          = sel_any & ~freeze_back;
    assign accept         = valid_dispatch & ready_dispatch & ~flush;
    assign slot           = count_q - CNT_W'(issue);

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            wk[i] = wakeup(q_q[i], valid_wb0, Pw_wb0, Result_wb0, valid_wb1, Pw_wb1, Result_wb1);
        for (int i = 0; i < DEPTH - 1; i++)
            up[i] = wk[i+1];
        up[DEPTH-1] = '0;
    end

    // New entry sees the same-cycle broadcasts so a matching wakeup is not lost.
    always_comb begin
        nd = '{valid: 1'b1, Pw: Pw_dispatch, Pa: Pa_dispatch, Pb: Pb_dispatch,
               rdyA: rdyA_dispatch, rdyB: rdyB_dispatch, valA: valA_dispatch,
               valB: valB_dispatch, tag_ROB: tag_ROB_dispatch};
        nd = wakeup(nd, valid_wb0, Pw_wb0, Result_wb0, valid_wb1, Pw_wb1, Result_wb1);
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef ADD_IQ_FAST_WAKEUP_EN
            req[i] = wk[i].valid & wk[i].rdyA & wk[i].rdyB;
`else
            req[i] = q_q[i].valid & q_q[i].rdyA & q_q[i].rdyB;
`endif
        end
    end

    iq_oldest_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_sel (
        .req_i (req),
        .gnt_o (gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    always_comb begin
        sel_pw  = '0;
        sel_a   = '0;
        sel_b   = '0;
        sel_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (gnt[i]) begin
`ifdef ADD_IQ_FAST_WAKEUP_EN
                sel_pw  = wk[i].Pw;
                sel_a   = wk[i].valA;
                sel_b   = wk[i].valB;
                sel_tag = wk[i].tag_ROB;
`else
                sel_pw  = q_q[i].Pw;
                sel_a   = q_q[i].valA;
                sel_b   = q_q[i].valB;
                sel_tag = q_q[i].tag_ROB;
`endif
            end
        end
    end

    // Compaction: everything above the issued slot moves down one.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            q_d[i] = (issue && i >= int'(sel_idx)) ? up[i] : wk[i];
            if (accept && i == int'(slot))
                q_d[i] = nd;
            if (flush)
                q_d[i] = '0;
        end
        count_d = flush ? '0 : count_q - CNT_W'(issue) + CNT_W'(accept);
    end

    always_comb begin
        valid_add_d = valid_add_q;
        pw_add_d    = pw_add_q;
        busa_d      = busa_q;
        busb_d      = busb_q;
        tag_d       = tag_q;
        if (flush) begin
            valid_add_d = 1'b0;
        end else if (!freeze_back) begin
            valid_add_d = sel_any;
            if (sel_any) begin
                pw_add_d = sel_pw;
                busa_d   = sel_a;
                busb_d   = sel_b;
                tag_d    = sel_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q         <= '0;
            count_q     <= '0;
            valid_add_q <= 1'b0;
            pw_add_q    <= '0;
            busa_q      <= '0;
            busb_q      <= '0;
            tag_q       <= '0;
        end else begin
            q_q         <= q_d;
            count_q     <= count_d;
            valid_add_q <= valid_add_d;
            pw_add_q    <= pw_add_d;
            busa_q      <= busa_d;
            busb_q      <= busb_d;
            tag_q       <= tag_d;
        end
    end

    assign valid_add   = valid_add_q;
    assign Pw_add      = pw_add_q;
    assign busA_add    = busa_q;
    assign busB_add    = busb_q;
    assign tag_ROB_add = tag_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= CNT_W'(DEPTH) && !(issue && count_q == '0));

endmodule

// File: doc/add_issue_queue.md
Name: add_issue_queue

Overview:
- Data-capturing reservation station for the 16-bit ADD execution unit.
- Sits between rename/dispatch and the ADD unit.
- Buffers dispatched ADD micro-ops and captures operands from two writeback broadcast buses.
- Issues the oldest fully-ready entry each cycle on the ADD unit's input interface (valid_add, Pw_add, busA_add, busB_add, tag_ROB_add).

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- PREG_W, 5, physical register tag width.
- DATA_W, 16, operand width.
- ROB_W, 4, ROB tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous squash of all entries.
- freeze_back  in  1  back-end stall: no issue, outputs hold.
- valid_dispatch  in  1  dispatch request.
- Pw_dispatch  in  PREG_W  destination physical register.
- Pa_dispatch  in  PREG_W  source A tag.
- Pb_dispatch  in  PREG_W  source B tag.
- rdyA_dispatch  in  1  source A value already valid.
- rdyB_dispatch  in  1  source B value already valid.
- valA_dispatch  in  DATA_W  source A value (used when rdyA_dispatch).
- valB_dispatch  in  DATA_W  source B value.
- tag_ROB_dispatch  in  ROB_W  ROB tag.
- ready_dispatch  out  1  queue can accept one dispatch this cycle.
- valid_wb0, valid_wb1  in  1  writeback broadcast valid.
- Pw_wb0, Pw_wb1  in  PREG_W  broadcast tag.
- Result_wb0, Result_wb1  in  DATA_W  broadcast data.
- valid_add  out  1  issue valid to ADD unit.
- Pw_add  out  PREG_W  issued destination.
- busA_add, busB_add  out  DATA_W  issued operands.
- tag_ROB_add  out  ROB_W  issued ROB tag.

Behaviour:
- Reset (rst low, async):
  - All entries invalid; count=0.
  - valid_add=0; Pw_add, busA_add, busB_add, tag_ROB_add = 0.
  - ready_dispatch=1 once rst releases.
- Storage:
  - Collapsing queue; index 0 is the oldest entry.
  - Each entry holds valid, Pw, Pa, Pb, rdyA, rdyB, valA, valB, tag_ROB.
- Wakeup:
  - Each edge, for every valid entry with rdyX=0: if valid_wbK and Pw_wbK==PX, set rdyX=1 and valX=Result_wbK.
  - If both buses match the same tag, wb0 wins.
  - Wakeup also applies to an entry being dispatched in the same cycle (dispatch-bypass): a same-cycle broadcast matching Pa_dispatch/Pb_dispatch must not be lost.
- Select/issue:
  - Combinational select picks the lowest-index entry with valid & rdyA & rdyB, evaluated on registered state.
  - When freeze_back=0, the selected entry's fields are registered to the outputs at the edge, the entry is removed, and younger entries shift down one slot.
  - If no entry is ready, valid_add goes to 0 at the edge.
  - Latency: operands ready at edge N → valid_add high after edge N+1 (minimum one cycle in queue).
- freeze_back=1:
  - No select and no removal; all output registers hold.
  - Wakeup and dispatch continue.
- Dispatch:
  - Accepted when valid_dispatch & ready_dispatch & ~flush.
  - Written to slot count, or count−1 when an issue/shift happens in the same cycle.
  - ready_dispatch = (count < DEPTH), taken from registered count. It is conservative: it ignores a same-cycle issue.
  - valid_dispatch while ready_dispatch=0 is ignored; the dispatcher must hold.
- flush (priority over everything except reset):
  - All entries invalidated and valid_add=0 at the edge, even with freeze_back=1.
  - Same-cycle dispatch dropped.
  - Other output fields hold their values.
- Boundaries:
  - Full plus same-cycle issue: no dispatch accepted that cycle.
  - Empty: valid_add=0.
  - count never exceeds DEPTH and never underflows; an assertion is required.
  - Reset mid-operation clears everything immediately.

Optional Feature:
- Macro ADD_IQ_FAST_WAKEUP_EN.
- Defined:
  - Select also treats a source as ready when a same-cycle broadcast matches it.
  - The issued operand takes Result_wbK directly.
  - An entry woken at cycle N can issue at edge N; the dispatch-to-issue minimum remains one cycle.
- Undefined: wakeup only takes effect at the edge, giving one extra cycle (behaviour as in Behaviour).

Decomposition:
- Shared package add_iq_pkg:
  - iq_entry_t struct (valid, Pw, Pa, Pb, rdyA, rdyB, valA, valB, tag_ROB).
  - Width constants PREG_W=5, DATA_W=16, ROB_W=4.
- One sub-module, iq_oldest_select: priority encoder giving a one-hot grant and index for the lowest ready entry.
- The shift/compaction logic stays in the top module.

Test Plan:
- Dispatch Pw=3, rdyA=rdyB=1, valA=0x0010, valB=0x0020, tag=5 into empty queue → next cycle valid_add=1, Pw_add=3, busA_add=0x0010, busB_add=0x0020, tag_ROB_add=5.
- Dispatch Pa=7 not ready; after 3 cycles pulse valid_wb1, Pw_wb1=7, Result_wb1=0xBEEF → issue one cycle later with busA_add=0xBEEF. Same tag on wb0 (0x1111) and wb1 in the same cycle → 0x1111 captured.
- Fill 4 entries (all waiting), then wake entries 2 and 0 together → entry 0 issues first, entry 2 next cycle. ready_dispatch=0 while count=4; a held valid_dispatch is accepted once count<4.
- freeze_back=1 for 2 cycles with a ready entry → outputs held and count unchanged; released → issue resumes oldest-first.
- flush with 3 entries and a same-cycle dispatch → next cycle valid_add=0 and count=0; a later dispatch issues normally.
- Assert rst low mid-stream, asynchronously between edges → valid_add=0 immediately and queue empty; with ADD_IQ_FAST_WAKEUP_EN, wakeup-cycle issue of a matched operand is observed.
